// File: rtl/temporizador_regressivo.sv
// Countdown timer: counts START_VALUE down to 0, one step every TICKS_PER_SEC
// clocks, with start/restart and pause/resume driven by button rising edges.
module temporizador_regressivo #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned START_VALUE   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] number,
    output logic       running,
    output logic       done
);

    localparam int unsigned PW      = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned CW      = 4;
    localparam int unsigned NW      = 7;
    localparam logic [NW-1:0] NUM_ZERO = NW'(10);
    localparam logic [NW-1:0] NUM_DASH = NW'(11);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            start_q, start_d;
    logic            pause_q, pause_d;
    logic [NW-1:0]   number_q, number_d;
    logic            running_q, running_d;
    logic            done_q, done_d;

    logic            start_edge_c;
    logic            pause_edge_c;
    logic            wrap_c;

    // Next-state, counters and registered display outputs
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        start_d   = start;
        pause_d   = pause;
        number_d  = number_q;
        running_d = 1'b0;
        done_d    = 1'b0;

        start_edge_c = start & ~start_q;
        pause_edge_c = pause & ~pause_q;
        wrap_c       = (presc_q == PW'(TICKS_PER_SEC - 1));

        if (start_edge_c) begin
            // A start edge restarts from any state and beats pause and wrap
            state_d = S_RUN;
            count_d = CW'(START_VALUE);
            presc_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    // This cycle counts as run time even if a pause arrives
                    if (wrap_c) begin
                        presc_d = '0;
                        count_d = count_q - CW'(1);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (wrap_c && (count_q == CW'(1))) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (pause_edge_c) begin
                        state_d = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (pause_edge_c) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        // Display follows the current state/count one cycle later
        running_d = (state_q == S_RUN);
        if (state_q == S_IDLE) begin
            number_d = NUM_DASH;
        end else if (count_q == '0) begin
            number_d = NUM_ZERO;
        end else begin
            number_d = NW'(count_q);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            number_q  <= NUM_DASH;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            start_q   <= start_d;
            pause_q   <= pause_d;
            number_q  <= number_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign number  = number_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Bench for temporizador_regressivo: directed scenarios followed by random
// button/reset activity, all checked cycle by cycle against an elapsed-time model.
module tb_temporizador_regressivo;

    localparam int unsigned T  = 4;
    localparam int unsigned SV = 9;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [6:0] number;
    logic       running;
    logic       done;

    always #5 clk = ~clk;

    temporizador_regressivo #(
        .TICKS_PER_SEC(T),
        .START_VALUE  (SV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .pause  (pause),
        .number (number),
        .running(running),
        .done   (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: mode plus run-time elapsed since the last start
    int m_mode    = M_IDLE;
    int m_elapsed = 0;
    bit m_sprev   = 1'b0;
    bit m_pprev   = 1'b0;
    int e_num     = 11;
    bit e_run     = 1'b0;
    bit e_done    = 1'b0;
    int done_seen = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit s, input bit p, input bit r);
        int digit;
        bit se;
        bit pe;
        if (!r) begin
            m_mode    = M_IDLE;
            m_elapsed = 0;
            m_sprev   = 1'b0;
            m_pprev   = 1'b0;
            e_num     = 11;
            e_run     = 1'b0;
            e_done    = 1'b0;
            return;
        end
        digit  = SV - (m_elapsed / T);
        e_num  = (m_mode == M_IDLE) ? 11 : ((digit == 0) ? 10 : digit);
        e_run  = (m_mode == M_RUN);
        e_done = 1'b0;
        se = s && !m_sprev;
        pe = p && !m_pprev;
        m_sprev = s;
        m_pprev = p;
        if (se) begin
            m_mode    = M_RUN;
            m_elapsed = 0;
        end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == SV * T) begin
                m_mode = M_DONE;
                e_done = 1'b1;
            end else if (pe) begin
                m_mode = M_PAUSED;
            end
        end else if (m_mode == M_PAUSED && pe) begin
            m_mode = M_RUN;
        end
    endtask

    // One clock: drive inputs, let the edge pass, then compare against the model
    task automatic cycle(input bit s, input bit p, input bit r);
        start = s;
        pause = p;
        rst_n = r;
        @(posedge clk);
        #1;
        model_step(s, p, r);
        if (done === 1'b1) done_seen++;
        check("number", int'(number), e_num);
        check("running", int'(running), int'(e_run));
        check("done", int'(done), int'(e_done));
        check("number_in_range", int'(number >= 7'd1 && number <= 7'd11), 1);
    endtask

    initial begin
        bit s_lvl;
        bit p_lvl;
        bit r_lvl;

        start = 1'b0;
        pause = 1'b0;
        rst_n = 1'b0;

        // Reset, then idle
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("reset_number", int'(number), 11);
        check("reset_running", int'(running), 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        check("idle_number", int'(number), 11);

        // Single start pulse: full countdown
        done_seen = 0;
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        check("start_latency_number", int'(number), 9);
        check("start_latency_running", int'(running), 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        check("first_step_number", int'(number), 8);
        for (int i = 0; i < 40; i++) cycle(0, 0, 1);
        check("done_hold_number", int'(number), 10);
        check("done_hold_running", int'(running), 0);
        check("single_done_pulse", done_seen, 1);

        // Pause two cycles into digit 5, hold, then resume
        cycle(1, 0, 1);
        for (int i = 0; i < 17; i++) cycle(0, 0, 1);
        check("before_pause_number", int'(number), 5);
        cycle(0, 1, 1);
        for (int i = 0; i < 19; i++) cycle(0, 1, 1);
        check("paused_number", int'(number), 5);
        check("paused_running", int'(running), 0);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("after_resume_number", int'(number), 4);

        // Start held for 50 cycles: one countdown only
        cycle(0, 0, 1);
        done_seen = 0;
        for (int i = 0; i < 50; i++) cycle(1, 0, 1);
        check("held_start_done_pulses", done_seen, 1);
        check("held_start_number", int'(number), 10);

        // Start and pause edges together mid-run: restart wins
        cycle(0, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        cycle(1, 1, 1);
        cycle(0, 0, 1);
        check("same_cycle_restart_number", int'(number), 9);
        check("same_cycle_restart_running", int'(running), 1);

        // Reset while showing 3, then restart
        cycle(1, 0, 1);
        for (int i = 0; i < 25; i++) cycle(0, 0, 1);
        check("pre_reset_number", int'(number), 3);
        cycle(0, 0, 0);
        check("mid_run_reset_number", int'(number), 11);
        check("mid_run_reset_running", int'(running), 0);
        cycle(0, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        check("post_reset_start_number", int'(number), 9);

        // Start held through reset counts as an edge after release
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        check("start_through_reset_number", int'(number), 9);

        // Random button and reset activity
        s_lvl = 1'b0;
        p_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) s_lvl = ~s_lvl;
            if ($urandom_range(0, 14) == 0) p_lvl = ~p_lvl;
            r_lvl = ($urandom_range(0, 299) != 0);
            cycle(s_lvl, p_lvl, r_lvl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
